// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for sync_fifo_flags and its bench.
package fifo_pkg;
  localparam int FIFO_AWIDTH = 4;
  typedef logic [FIFO_AWIDTH:0] fifo_cnt_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_UDF} fifo_err_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DWIDTH x 2**AWIDTH storage, synchronous write, asynchronous read.
module fifo_ram #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] mem [1<<AWIDTH];
  always_ff @(posedge clock) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock show-ahead FIFO with occupancy and level flags.
// Sticky overflow/underflow flags are built only when SYNC_FIFO_ERR_EN is defined.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = FIFO_AWIDTH,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              f_full,
  output logic              f_empty,
  output logic              f_afull,
  output logic              f_aempty,
  output logic [AWIDTH:0]   count,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [AWIDTH:0] AF_C = AF_LEVEL[AWIDTH:0];
  localparam logic [AWIDTH:0] AE_C = AE_LEVEL[AWIDTH:0];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              wr_acc, rd_acc;
  // count never exceeds DEPTH, so its top bit alone marks full
  assign f_full   = count_q[AWIDTH];
  assign f_empty  = count_q == '0;
  assign f_afull  = count_q >= AF_C;
  assign f_aempty = count_q <= AE_C;
  assign count    = count_q;
  assign wr_acc   = wr_en & ~f_full;
  assign rd_acc   = rd_en & ~f_empty;
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (wr_acc & ~rd_acc) ? count_q + 1'b1 :
               (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  fifo_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
    .clock(clock),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(data_in),
    .raddr(rd_ptr_q),
    .rdata(data_out)
  );
`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  // set terms are ORed after the clear so a same-cycle set wins
  always_comb begin
    overflow_d  = (wr_en & f_full)  | (overflow_q  & ~err_clr);
    underflow_d = (rd_en & f_empty) | (underflow_q & ~err_clr);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed checks of fill/drain, simultaneous access, wrap, reset and error flags.
module tb_sync_fifo_flags;
  import fifo_pkg::*;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit E = 1'b1;
`else
  localparam bit E = 1'b0;
`endif
  logic        clock = 0, reset = 0, wr_en = 0, rd_en = 0, err_clr = 0;
  logic [31:0] data_in = '0, data_out;
  logic        f_full, f_empty, f_afull, f_aempty, overflow, underflow;
  fifo_cnt_t   count;
  int          checks = 0, failures = 0;
  sync_fifo_flags #(.DWIDTH(32), .AWIDTH(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .f_full(f_full), .f_empty(f_empty), .f_afull(f_afull),
    .f_aempty(f_aempty), .count(count), .err_clr(err_clr), .overflow(overflow),
    .underflow(underflow)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic r, input logic [31:0] d, input logic c = 1'b0, input logic rs = 1'b0);
    @(negedge clock);
    wr_en = w; rd_en = r; data_in = d; err_clr = c; reset = rs;
    @(posedge clock);
    #1;
    wr_en = 0; rd_en = 0; err_clr = 0; reset = 0;
  endtask
  initial begin
    cyc(0, 0, 0, 0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(f_empty), 1);
    chk("rst_aempty", 32'(f_aempty), 1);
    chk("rst_full", 32'(f_full), 0);
    chk("rst_afull", 32'(f_afull), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 32'h100 + 32'(i));
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(f_afull), 32'(i + 1 >= 12));
      chk("fill_aempty", 32'(f_aempty), 32'(i + 1 <= 4));
      chk("fill_full", 32'(f_full), 32'(i == 15));
      chk("fill_head", data_out, 32'h100);
    end
    chk("fill_ovf", 32'(overflow), 0);
    cyc(1, 0, 32'hBAD);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_set", 32'(overflow), 32'(E));
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", data_out, 32'h100 + 32'(i));
      cyc(0, 1, 0);
      chk("drain_count", 32'(count), 32'(15 - i));
      chk("drain_aempty", 32'(f_aempty), 32'(15 - i <= 4));
      chk("drain_empty", 32'(f_empty), 32'(i == 15));
    end
    chk("drain_udf", 32'(underflow), 0);
    cyc(0, 1, 0);
    chk("udf_set", 32'(underflow), 32'(E));
    chk("udf_count", 32'(count), 0);
    cyc(0, 0, 0, 1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 32'h200 + 32'(i));
    for (int k = 0; k < 8; k++) begin
      chk("sim_data", data_out, k < 5 ? 32'h200 + 32'(k) : 32'h300 + 32'(k - 5));
      cyc(1, 1, 32'h300 + 32'(k));
      chk("sim_count", 32'(count), 5);
    end
    for (int i = 0; i < 11; i++) cyc(1, 0, 32'h400 + 32'(i));
    chk("sim_full", 32'(f_full), 1);
    chk("sim_head", data_out, 32'h303);
    cyc(1, 1, 32'hBEEF);
    chk("full_both_count", 32'(count), 15);
    chk("full_both_ovf", 32'(overflow), 32'(E));
    for (int i = 0; i < 15; i++) begin
      chk("full_both_data", data_out, i < 4 ? 32'h304 + 32'(i) : 32'h400 + 32'(i - 4));
      cyc(0, 1, 0);
    end
    chk("full_both_empty", 32'(f_empty), 1);
    cyc(1, 1, 32'h555);
    chk("empty_both_count", 32'(count), 1);
    chk("empty_both_udf", 32'(underflow), 32'(E));
    chk("empty_both_data", data_out, 32'h555);
    cyc(0, 1, 0, 1);
    chk("empty_both_drain", 32'(count), 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 32'h50 + 32'(i));
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);
    for (int i = 0; i < 16; i++) cyc(1, 0, 32'hA0 + 32'(i));
    chk("wrap_full", 32'(f_full), 1);
    for (int i = 0; i < 16; i++) begin
      chk("wrap_data", data_out, 32'hA0 + 32'(i));
      cyc(0, 1, 0);
    end
    chk("wrap_empty", 32'(f_empty), 1);
    cyc(0, 1, 0);
    chk("pre_rst_udf", 32'(underflow), 32'(E));
    for (int i = 0; i < 7; i++) cyc(1, 0, 32'h700 + 32'(i));
    chk("pre_rst_count", 32'(count), 7);
    cyc(1, 1, 32'h999, 0, 1);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(f_empty), 1);
    chk("mid_rst_udf", 32'(underflow), 0);
    cyc(1, 0, 32'hDEAD);
    chk("dead_data", data_out, 32'hDEAD);
    chk("dead_count", 32'(count), 1);
    cyc(0, 1, 0);
    chk("dead_empty", 32'(f_empty), 1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 32'(i));
    cyc(1, 0, 32'hF00);
    chk("ec_ovf_set", 32'(overflow), 32'(E));
    cyc(0, 0, 0, 1);
    chk("ec_ovf_clr", 32'(overflow), 0);
    cyc(1, 0, 32'hF01, 1);
    chk("ec_set_wins", 32'(overflow), 32'(E));
    chk("ec_count", 32'(count), 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
